// File: rtl/fir_result_buffer_pkg.sv
// Shared constants for the FIR accelerator result path.
//
// Purpose : single source of the widths and depths used by the accelerator
//           top and by fir_result_buffer, so both always agree.
// Contents: DATA_WIDTH, ACC_WIDTH, NUM_REGS, FRAC_BITS, RES_FIFO_DEPTH and a
//           small helper that sizes the warm-up counter.
package fir_result_buffer_pkg;

  localparam int DATA_WIDTH     = 32;  // output sample width
  localparam int ACC_WIDTH      = 64;  // MAC accumulator width
  localparam int NUM_REGS       = 8;   // filter taps
  localparam int FRAC_BITS      = 15;  // coefficient fractional bits
  localparam int RES_FIFO_DEPTH = 4;   // result FIFO entries (power of 2)

  // Width needed to count 0..max_val inclusive, never less than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/fir_result_buffer_result_fifo.sv
// result_fifo: first-word-fall-through FIFO holding scaled FIR results.
//
// Ports:
//   clk, rst       - rising-edge clock, asynchronous active-high reset
//   flush          - synchronous clear of pointers and occupancy (wins over push/pop)
//   push           - a new entry is offered this cycle
//   push_data      - the entry offered
//   pop_req        - consumer takes the head this cycle (ignored when empty)
//   pop_data       - current head, forced to zero while empty
//   not_empty      - head is valid
//   count          - number of stored entries
//   drop           - the offered entry is discarded: full and no pop this edge
//
// A pop and a push on the same edge are both performed even when full; the
// freed slot is the one the write pointer lands on after wrap-around.
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_req,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       not_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop_req && !empty;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign not_empty = !empty;
  assign count     = cnt;
  assign pop_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fir_result_buffer.sv
// fir_result_buffer: scales, saturates and buffers FIR MAC results.
//
// Each macResult is rounded half-up from FRAC_BITS fractional bits, clamped to
// the signed DATA_WIDTH range, and, once the filter has seen NUM_REGS samples,
// staged for one cycle before being written into result_fifo.
//
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   flush      - synchronous clear of FIFO, stage, warm-up counter and flags
//   macValid   - macResult carries a new filter output this cycle
//   macResult  - signed ACC_WIDTH accumulator value
//   resValid   - FIFO head valid
//   resReady   - consumer takes the head this cycle
//   resData    - signed FIFO head (first-word-fall-through, 0 when empty)
//   count      - FIFO occupancy
//   overflow   - sticky: a staged result was dropped on a full FIFO
//   satFlag    - sticky: an enqueued result was clamped
//
// Handshake: a result transfers on any rising edge where resValid and
// resReady are both high; resValid never depends on resReady, and resData
// holds steady while resValid is high and resReady is low (flush excepted).
module fir_result_buffer
  import fir_result_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = fir_result_buffer_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH  = fir_result_buffer_pkg::ACC_WIDTH,
  parameter int NUM_REGS   = fir_result_buffer_pkg::NUM_REGS,
  parameter int FRAC_BITS  = fir_result_buffer_pkg::FRAC_BITS,
  parameter int DEPTH      = fir_result_buffer_pkg::RES_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       macValid,
  input  logic [ACC_WIDTH-1:0]       macResult,
  output logic                       resValid,
  input  logic                       resReady,
  output logic [DATA_WIDTH-1:0]      resData,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       satFlag
);

  localparam int EW = ACC_WIDTH + 1;             // one guard bit for the rounding add
  localparam int WW = cnt_width(NUM_REGS - 1);   // warm-up counter width
  localparam logic [WW-1:0] WARM_MAX = WW'(NUM_REGS - 1);

  // Half an LSB of the output; zero when there are no fractional bits.
  localparam logic signed [EW-1:0] HALF =
    (FRAC_BITS > 0) ? (EW'(1) << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0)) : '0;
  localparam logic signed [EW-1:0] MAX_V =
    {{(EW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V =
    {{(EW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Scaling datapath
  logic signed [EW-1:0]   ext_sum;
  logic signed [EW-1:0]   rounded;
  logic [DATA_WIDTH-1:0]  scaled;
  logic                   clamped;

  // Warm-up and pipeline stage
  logic [WW-1:0]          warm_cnt;
  logic                   eligible;
  logic                   stage_valid;
  logic [DATA_WIDTH-1:0]  stage_data;
  logic                   stage_sat;

  // FIFO interface
  logic                   fifo_drop;
  logic                   ovf_q;
  logic                   sat_q;

  always_comb begin
    ext_sum = $signed({macResult[ACC_WIDTH-1], macResult}) + HALF;
    rounded = ext_sum >>> FRAC_BITS;
    scaled  = rounded[DATA_WIDTH-1:0];
    clamped = 1'b0;
    if (rounded > MAX_V) begin
      scaled  = MAX_V[DATA_WIDTH-1:0];
      clamped = 1'b1;
    end else if (rounded < MIN_V) begin
      scaled  = MIN_V[DATA_WIDTH-1:0];
      clamped = 1'b1;
    end
  end

  // The counter only advances on discarded pulses, so it parks at WARM_MAX
  // and every later pulse is eligible.
  assign eligible = macValid && (warm_cnt == WARM_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt    <= '0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
      stage_sat   <= 1'b0;
      ovf_q       <= 1'b0;
      sat_q       <= 1'b0;
    end else if (flush) begin
      warm_cnt    <= '0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
      stage_sat   <= 1'b0;
      ovf_q       <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      if (macValid && !eligible) warm_cnt <= warm_cnt + WW'(1);
      stage_valid <= eligible;
      if (eligible) begin
        stage_data <= scaled;
        stage_sat  <= clamped;
      end
      if (fifo_drop) ovf_q <= 1'b1;
      // Only results that actually land in the FIFO count as saturated.
      if (stage_valid && stage_sat && !fifo_drop) sat_q <= 1'b1;
    end
  end

  result_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (stage_valid),
    .push_data (stage_data),
    .pop_req   (resReady),
    .pop_data  (resData),
    .not_empty (resValid),
    .count     (count),
    .drop      (fifo_drop)
  );

  assign overflow = ovf_q;
  assign satFlag  = sat_q;

endmodule

// File: tb/tb_fir_result_buffer.sv
// Bench for fir_result_buffer: directed scenarios followed by a random phase,
// all compared against a queue-based reference model after every clock edge.
module tb_fir_result_buffer;

  localparam int DW    = 32;
  localparam int AW    = 64;
  localparam int NR    = 8;
  localparam int FB    = 15;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          macValid;
  logic [AW-1:0] macResult;
  logic          resReady;
  logic          resValid;
  logic [DW-1:0] resData;
  logic [CW-1:0] count;
  logic          overflow;
  logic          satFlag;

  always #5 clk = ~clk;

  fir_result_buffer #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .NUM_REGS   (NR),
    .FRAC_BITS  (FB),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .macValid  (macValid),
    .macResult (macResult),
    .resValid  (resValid),
    .resReady  (resReady),
    .resData   (resData),
    .count     (count),
    .overflow  (overflow),
    .satFlag   (satFlag)
  );

  // ---------------- scoreboard / reference model ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic          m_stage_v;
  logic [DW-1:0] m_stage_d;
  logic          m_stage_s;
  int            m_pulses;
  logic          m_ovf;
  logic          m_sat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns {clamped, value}: round-half-up then clamp, in wide signed arithmetic.
  function automatic logic [DW:0] ref_scale(input logic [AW-1:0] m);
    logic signed [127:0] w, hi, lo;
    hi = (128'sd1 <<< (DW-1)) - 128'sd1;
    lo = -(128'sd1 <<< (DW-1));
    w  = $signed({{(128-AW){m[AW-1]}}, m});
    w  = (w + (128'sd1 <<< (FB-1))) >>> FB;
    if (w > hi) return {1'b1, hi[DW-1:0]};
    if (w < lo) return {1'b1, lo[DW-1:0]};
    return {1'b0, w[DW-1:0]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_stage_v = 1'b0;
    m_stage_d = '0;
    m_stage_s = 1'b0;
    m_pulses  = 0;
    m_ovf     = 1'b0;
    m_sat     = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic          do_pop;
    logic          accept;
    logic [DW:0]   r;
    if (flush) begin
      model_reset();
      return;
    end
    do_pop = resReady && (exp_q.size() > 0);
    accept = 1'b0;
    if (m_stage_v) begin
      if (exp_q.size() < DEPTH || do_pop) begin
        accept = 1'b1;
        if (m_stage_s) m_sat = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (do_pop) void'(exp_q.pop_front());
    if (accept) exp_q.push_back(m_stage_d);
    m_stage_v = 1'b0;
    if (macValid) begin
      m_pulses++;
      if (m_pulses >= NR) begin
        r         = ref_scale(macResult);
        m_stage_v = 1'b1;
        m_stage_s = r[DW];
        m_stage_d = r[DW-1:0];
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk({tag, ".valid"},    resValid, exp_q.size() > 0);
    chk({tag, ".data"},     resData,  head);
    chk({tag, ".count"},    count,    exp_q.size());
    chk({tag, ".overflow"}, overflow, m_ovf);
    chk({tag, ".sat"},      satFlag,  m_sat);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse(input string tag, input logic [AW-1:0] v);
    macValid  = 1'b1;
    macResult = v;
    tick(tag);
    macValid  = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] exp_round[4];

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    macValid  = 1'b0;
    macResult = '0;
    resReady  = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Warm-up: only the eighth pulse survives, two edges later.
    for (int k = 1; k <= NR; k++) pulse("warm", 64'(k) * 64'd32768);
    tick("warm.lat1");
    chk("warm.res_valid", resValid, 1'b1);
    chk("warm.res_data",  resData,  32'd8);
    chk("warm.count",     count,    3'd1);
    resReady = 1'b1;
    tick("warm.drain");
    resReady = 1'b0;

    // Rounding around the half-LSB boundary.
    exp_round = '{32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF};
    pulse("round", 64'sd16384);
    pulse("round", 64'sd16383);
    pulse("round", -64'sd16384);
    pulse("round", -64'sd16385);
    idle("round.settle", 2);
    for (int i = 0; i < 4; i++) begin
      chk("round.value", resData, exp_round[i]);
      resReady = 1'b1;
      tick("round.drain");
      resReady = 1'b0;
    end
    chk("round.sat", satFlag, 1'b0);

    // Saturation at both rails.
    pulse("sat", 64'h7FFF_FFFF_FFFF_FFFF);
    pulse("sat", 64'h8000_0000_0000_0000);
    idle("sat.settle", 2);
    chk("sat.hi", resData, 32'h7FFF_FFFF);
    chk("sat.flag", satFlag, 1'b1);
    resReady = 1'b1;
    tick("sat.pop1");
    chk("sat.lo", resData, 32'h8000_0000);
    tick("sat.pop2");
    resReady = 1'b0;

    // Overflow: six results into a four-deep FIFO with no consumer.
    for (int k = 1; k <= 6; k++) pulse("ovf", 64'(k) * 64'd32768);
    idle("ovf.settle", 2);
    chk("ovf.count", count, 3'd4);
    chk("ovf.flag",  overflow, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf.order", resData, 32'(k));
      resReady = 1'b1;
      tick("ovf.drain");
      resReady = 1'b0;
    end

    // Flush, fresh warm-up, then push and pop together on a full FIFO.
    flush = 1'b1;
    macValid = 1'b1;
    resReady = 1'b1;
    macResult = 64'd32768;
    tick("flush");
    flush = 1'b0;
    macValid = 1'b0;
    resReady = 1'b0;
    chk("flush.overflow", overflow, 1'b0);
    chk("flush.sat",      satFlag,  1'b0);
    for (int k = 1; k < NR; k++) pulse("flush.warm", 64'd99 * 64'd32768);
    idle("flush.settle", 2);
    chk("flush.empty", count, 3'd0);
    for (int k = 10; k <= 13; k++) pulse("full.fill", 64'(k) * 64'd32768);
    idle("full.settle", 2);
    chk("full.count", count, 3'd4);
    pulse("full.stage", 64'd14 * 64'd32768);
    resReady = 1'b1;
    tick("full.pushpop");
    resReady = 1'b0;
    chk("full.count_kept", count, 3'd4);
    chk("full.no_ovf", overflow, 1'b0);
    for (int k = 11; k <= 14; k++) begin
      chk("full.wrap_order", resData, 32'(k));
      resReady = 1'b1;
      tick("full.drain");
      resReady = 1'b0;
    end

    // Asynchronous reset between edges with data in flight.
    pulse("mid", 64'd20 * 64'd32768);
    pulse("mid", 64'd21 * 64'd32768);
    idle("mid.settle", 1);
    macValid  = 1'b1;
    macResult = 64'd22 * 64'd32768;
    #2;
    rst = 1'b1;
    #1;
    chk("areset.valid",    resValid, 1'b0);
    chk("areset.data",     resData,  32'd0);
    chk("areset.count",    count,    3'd0);
    chk("areset.overflow", overflow, 1'b0);
    chk("areset.sat",      satFlag,  1'b0);
    model_reset();
    macValid = 1'b0;
    #2;
    rst = 1'b0;
    for (int k = 1; k < NR; k++) pulse("rewarm", 64'd77 * 64'd32768);
    idle("rewarm.settle", 2);
    chk("rewarm.empty", count, 3'd0);
    pulse("rewarm.last", 64'd5 * 64'd32768);
    idle("rewarm.lat", 1);
    chk("rewarm.valid", resValid, 1'b1);
    chk("rewarm.data",  resData,  32'd5);

    // Random phase against the model.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] v;
      case ($urandom_range(0, 3))
        0: v = 64'($signed(int'($urandom_range(0, 2000000)) - 1000000));
        1: v = {$urandom, $urandom};
        2: v = 64'($signed(int'($urandom_range(0, 200)) - 100)) * 64'd32768
               + 64'd16384 + 64'($signed(int'($urandom_range(0, 2)) - 1));
        default: begin
          v = (64'd1 << 46) + 64'($signed(int'($urandom_range(0, 65536)) - 32768));
          if ($urandom_range(0, 1) == 1) v = -v;
        end
      endcase
      macValid  = ($urandom_range(0, 3) != 0);
      macResult = v;
      resReady  = ($urandom_range(0, 2) != 0) && (n % 50 > 12);
      flush     = ($urandom_range(0, 60) == 0);
      tick("rand");
    end
    macValid = 1'b0;
    flush    = 1'b0;
    resReady = 1'b1;
    idle("final.drain", 6);
    chk("final.empty", count, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_result_buffer.md
FIR_RESULT_BUFFER -- requirements
Module: fir_result_buffer

Interface
REQ-001 The module SHALL take parameter DATA_WIDTH, default 32, as the output sample width.
REQ-002 The module SHALL take parameter ACC_WIDTH, default 64, as the MAC accumulator width.
REQ-003 The module SHALL take parameter NUM_REGS, default 8, as the number of filter taps.
REQ-004 The module SHALL take parameter FRAC_BITS, default 15, as the coefficient fractional bits.
REQ-005 The module SHALL take parameter DEPTH, default 4, as the FIFO entry count (power of 2).
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The module SHALL have port flush, input, 1 bit: synchronous clear of all state.
REQ-009 The module SHALL have port macValid, input, 1 bit: macResult holds a new filter output this cycle.
REQ-010 The module SHALL have port macResult, input, ACC_WIDTH bits: signed two's-complement accumulator.
REQ-011 The module SHALL have port resValid, output, 1 bit: FIFO head valid.
REQ-012 The module SHALL have port resReady, input, 1 bit: consumer takes the head this cycle.
REQ-013 The module SHALL have port resData, output, DATA_WIDTH bits: signed FIFO head, first-word-fall-through.
REQ-014 The module SHALL have port count, output, clog2(DEPTH+1) bits: FIFO occupancy.
REQ-015 The module SHALL have port overflow, output, 1 bit: sticky, a result was dropped.
REQ-016 The module SHALL have port satFlag, output, 1 bit: sticky, a result was saturated.

Function
REQ-017 The module SHALL scale each result as round = (macResult + 2^(FRAC_BITS-1)) >>> FRAC_BITS, computed at ACC_WIDTH+1 bits (arithmetic shift, round-half-up).
REQ-018 The module SHALL clamp round to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and set satFlag whenever a clamp occurs on an enqueued result.
REQ-019 The module SHALL discard the first NUM_REGS-1 macValid pulses after reset or flush (warm-up), using a counter that saturates at NUM_REGS-1; from the NUM_REGS-th pulse onward, every pulse is eligible for enqueue.
REQ-020 The module SHALL register each eligible scaled result in one pipeline stage at edge N (macValid high before edge N) and write it into the FIFO at edge N+1, so resValid rises after edge N+1 into an empty FIFO (latency 2 cycles).
REQ-021 The module SHALL complete a pop on any edge where resValid and resReady are both high; resReady with an empty FIFO has no effect.
REQ-022 The module SHALL, when the FIFO is full at the write edge and no pop occurs, drop the staged result, leave the FIFO contents unchanged, and set overflow.
REQ-023 The module SHALL, on a simultaneous push and pop (including when full), perform both, leave count unchanged, and not set overflow.
REQ-024 The module SHALL preserve FIFO order across pointer wrap-around; count SHALL equal the number of stored entries at all times.
REQ-025 The module SHALL, on flush, clear the FIFO, the pipeline stage, the warm-up counter, overflow and satFlag on the next edge; flush SHALL take priority over macValid and resReady in the same cycle.
REQ-026 The module SHALL drive resData to 0 whenever the FIFO is empty.

Reset
REQ-027 The module SHALL, on rst high, immediately (without waiting for clk) force resValid=0, resData=0, count=0, overflow=0, satFlag=0, empty both the pipeline stage and the FIFO, and zero the warm-up counter.
REQ-028 The module SHALL restart warm-up after rst is released mid-stream, exactly as after power-up.

Structure
REQ-029 The module SHALL take DATA_WIDTH, ACC_WIDTH, NUM_REGS, FRAC_BITS and RES_FIFO_DEPTH defaults from the shared constants header used by the accelerator top.
REQ-030 The module SHALL implement the FIFO storage, pointers and count as one sub-module named result_fifo; the scale, saturate, warm-up and pipeline logic SHALL stay in fir_result_buffer.

Verification (NUM_REGS=8, FRAC_BITS=15, DEPTH=4)
REQ-031 The bench SHALL cover warm-up: 8 macValid pulses with macResult=k*32768 for k=1..8 -> only k=8 is enqueued; resData=8 and resValid=1 two cycles after the 8th pulse.
REQ-032 The bench SHALL cover rounding: post-warm-up inputs 16384, 16383, -16384 and -16385 -> resData 1, 0, 0, -1; satFlag stays 0.
REQ-033 The bench SHALL cover saturation: inputs 0x7FFF_FFFF_FFFF_FFFF and 0x8000_0000_0000_0000 -> resData 0x7FFF_FFFF and 0x8000_0000; satFlag=1.
REQ-034 The bench SHALL cover overflow: resReady=0 and 6 post-warm-up results 1..6 -> count=4, overflow=1; then draining yields 1, 2, 3, 4 in order.
REQ-035 The bench SHALL cover full push/pop: with the FIFO full, resReady=1 together with a new result -> count stays 4, overflow stays 0, and the order is preserved across wrap.
REQ-036 The bench SHALL cover reset and flush: rst asserted between clock edges mid-stream -> all outputs are 0 before the next edge; after flush, 7 pulses enqueue nothing and the 8th enqueues.
